// File: rtl/seq_pkg.sv
// Shared constants and types for the serial frame transmitter and its paired detector.
package seq_pkg;

    localparam int FRAME_W = 6;
    localparam logic [FRAME_W-1:0] IDLE_WORD_DEF = 6'b000000;
    localparam logic [FRAME_W-1:0] MATCH_WORD    = 6'b011100;

    typedef logic [FRAME_W-1:0] frame_t;

    localparam int SLOT_CNT_W = $clog2(FRAME_W);

    // Counter width for an arbitrary frame width; never narrower than one bit.
    function automatic int slot_cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_slot_cnt.sv
// Free-running 0..W-1 slot counter shared by transmitter and detector so both
// sides agree on frame alignment from reset.
module seq_slot_cnt
    import seq_pkg::*;
#(
    parameter int W    = FRAME_W,
    parameter int CW   = slot_cnt_width(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] cnt,
    output logic          last
);

    assign last = (cnt == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sequence_gen.sv
// Serial frame transmitter: one-entry holding buffer feeding a W-bit shift register.
// Bit order is MSB-first unless SEQ_TX_LSB_FIRST_EN is defined (then LSB-first).
module sequence_gen
    import seq_pkg::*;
#(
    parameter int           W         = FRAME_W,
    parameter logic [W-1:0] IDLE_WORD = W'(IDLE_WORD_DEF)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         data_out,
    output logic         frame_start,
    output logic         underrun
);

    localparam int CW = slot_cnt_width(W);

    logic [CW-1:0] cnt;
    logic          last;
    logic [W-1:0]  sreg;
    logic [W-1:0]  hold_data;
    logic          hold_valid;
    logic          accept;
    logic          hold_we;
    logic [W-1:0]  load_word;
    logic          load_idle;

`ifdef SEQ_TX_LSB_FIRST_EN
    function automatic logic [W-1:0] shift_next(input logic [W-1:0] s);
        return {1'b0, s[W-1:1]};
    endfunction

    assign data_out = sreg[0];
`else
    function automatic logic [W-1:0] shift_next(input logic [W-1:0] s);
        return {s[W-2:0], 1'b0};
    endfunction

    assign data_out = sreg[W-1];
`endif

    seq_slot_cnt #(
        .W  (W),
        .CW (CW)
    ) u_slot_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .last  (last)
    );

    assign frame_start = (cnt == '0);
    assign in_ready    = !hold_valid || last;
    assign accept      = in_valid && in_ready;

    // At a boundary with a held word, a new accept refills hold behind it.
    assign hold_we = accept && (!last || hold_valid);

    always_comb begin
        load_word = IDLE_WORD;
        load_idle = 1'b0;
        if (hold_valid) begin
            load_word = hold_data;
        end else if (accept) begin
            load_word = in_data;
        end else begin
            load_idle = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= last && load_idle;
            if (last) begin
                hold_valid <= hold_valid && accept;
            end else if (accept) begin
                hold_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= IDLE_WORD;
        end else if (last) begin
            sreg <= load_word;
        end else begin
            sreg <= shift_next(sreg);
        end
    end

    // Hold contents are only meaningful while hold_valid is set, so no reset.
    always_ff @(posedge clk) begin
        if (hold_we) begin
            hold_data <= in_data;
        end
    end

endmodule

// File: tb/tb_sequence_gen.sv
// Directed bench for sequence_gen with a behavioural looped-back frame detector.
module tb_sequence_gen;
    import seq_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [5:0]   in_data;
    logic         data_out;
    logic         frame_start;
    logic         underrun;

    int errors = 0;
    int checks = 0;

    // Detector model: non-overlapping 6-bit frames, MSB-first, match registered at frame end.
    int       dcnt;
    logic [5:0] dsh;
    logic     match;

    sequence_gen #(
        .W         (6),
        .IDLE_WORD (6'b000000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .data_out    (data_out),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt  <= 0;
            dsh   <= '0;
            match <= 1'b0;
        end else begin
            dsh <= {dsh[4:0], data_out};
            if (dcnt == 5) begin
                dcnt  <= 0;
                match <= ({dsh[4:0], data_out} == MATCH_WORD);
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    // Leaves the bench at the start of cycle 0 (just after rst_n release).
    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_idle();
        do_reset();
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            checks++;
            if (data_out !== 1'b0) begin
                errors++;
                $display("FAIL idle_data c=%0d got=%b exp=0", c, data_out);
            end
            checks++;
            if (frame_start !== (c % 6 == 0)) begin
                errors++;
                $display("FAIL idle_frame_start c=%0d got=%b exp=%b", c, frame_start, (c % 6 == 0));
            end
            checks++;
            if (underrun !== (c == 6 || c == 12)) begin
                errors++;
                $display("FAIL idle_underrun c=%0d got=%b exp=%b", c, underrun, (c == 6 || c == 12));
            end
            next_cycle();
        end
    endtask

    task automatic test_held_loopback();
        logic [5:0] exp_bits;
        exp_bits = 6'b011100;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            in_valid = (c == 2);
            in_data  = (c == 2) ? 6'b011100 : 6'b000000;
            @(negedge clk);
            if (c >= 3 && c <= 5) begin
                checks++;
                if (in_ready !== (c == 5)) begin
                    errors++;
                    $display("FAIL held_in_ready c=%0d got=%b exp=%b", c, in_ready, (c == 5));
                end
            end
            if (c >= 6 && c <= 11) begin
                checks++;
                if (data_out !== exp_bits[11 - c]) begin
                    errors++;
                    $display("FAIL held_data c=%0d got=%b exp=%b", c, data_out, exp_bits[11 - c]);
                end
            end
            if (c == 6) begin
                checks++;
                if (underrun !== 1'b0) begin
                    errors++;
                    $display("FAIL held_underrun got=%b exp=0", underrun);
                end
            end
            if (c == 11 || c == 12) begin
                checks++;
                if (match !== (c == 12)) begin
                    errors++;
                    $display("FAIL loopback_match c=%0d got=%b exp=%b", c, match, (c == 12));
                end
            end
            next_cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_bypass();
        logic [5:0] exp_bits;
        exp_bits = 6'b101010;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            in_valid = (c == 5);
            in_data  = (c == 5) ? 6'b101010 : 6'b000000;
            @(negedge clk);
            if (c == 5) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bypass_ready got=%b exp=1", in_ready);
                end
            end
            if (c == 6) begin
                checks++;
                if (underrun !== 1'b0) begin
                    errors++;
                    $display("FAIL bypass_underrun got=%b exp=0", underrun);
                end
            end
            if (c >= 6) begin
                checks++;
                if (data_out !== exp_bits[11 - c]) begin
                    errors++;
                    $display("FAIL bypass_data c=%0d got=%b exp=%b", c, data_out, exp_bits[11 - c]);
                end
            end
            next_cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_streaming();
        logic [5:0] words [3];
        logic [17:0] stream;
        int          idx;
        logic        acc;
        words[0] = 6'b110011;
        words[1] = 6'b010110;
        words[2] = 6'b100101;
        stream   = {words[0], words[1], words[2]};
        idx      = 0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            in_valid = (idx < 3);
            in_data  = (idx < 3) ? words[idx] : 6'b000000;
            @(negedge clk);
            acc = in_valid && in_ready;
            checks++;
            if (acc !== (c == 0 || c == 5 || c == 11)) begin
                errors++;
                $display("FAIL stream_accept c=%0d got=%b exp=%b", c, acc, (c == 0 || c == 5 || c == 11));
            end
            if (acc) idx++;
            if (c >= 1) begin
                checks++;
                if (underrun !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_underrun c=%0d got=%b exp=0", c, underrun);
                end
            end
            if (c >= 6) begin
                checks++;
                if (data_out !== stream[23 - c]) begin
                    errors++;
                    $display("FAIL stream_data c=%0d got=%b exp=%b", c, data_out, stream[23 - c]);
                end
            end
            next_cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            in_valid = (c == 2 || c == 7);
            in_data  = (c == 2) ? 6'b111111 : ((c == 7) ? 6'b101101 : 6'b000000);
            next_cycle();
        end
        in_valid = 1'b0;
        // Now in cycle 9: frame 6'b111111 in flight, 6'b101101 held.
        @(negedge clk);
        checks++;
        if (data_out !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre got=%b%b exp=10", data_out, in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 1'b0) begin
            errors++;
            $display("FAIL midrst_data got=%b exp=0", data_out);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (underrun !== 1'b0 || frame_start !== 1'b1) begin
            errors++;
            $display("FAIL midrst_flags got=%b%b exp=01", underrun, frame_start);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (data_out !== 1'b0) begin
                errors++;
                $display("FAIL midrst_after_data c=%0d got=%b exp=0", c, data_out);
            end
            checks++;
            if (underrun !== (c == 6)) begin
                errors++;
                $display("FAIL midrst_after_underrun c=%0d got=%b exp=%b", c, underrun, (c == 6));
            end
            next_cycle();
        end
    endtask

    task automatic test_bit_order();
        logic [5:0] exp_bits;
`ifdef SEQ_TX_LSB_FIRST_EN
        exp_bits = 6'b000011;
`else
        exp_bits = 6'b110000;
`endif
        do_reset();
        for (int c = 0; c < 12; c++) begin
            in_valid = (c == 5);
            in_data  = (c == 5) ? 6'b110000 : 6'b000000;
            @(negedge clk);
            if (c >= 6) begin
                checks++;
                if (data_out !== exp_bits[11 - c]) begin
                    errors++;
                    $display("FAIL order_data c=%0d got=%b exp=%b", c, data_out, exp_bits[11 - c]);
                end
            end
            next_cycle();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset_idle();
        test_held_loopback();
        test_bypass();
        test_streaming();
        test_reset_mid_frame();
        test_bit_order();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sequence_gen.md
# sequence_gen

Serial frame transmitter that pairs with the non-overlapping 6-bit sequence detector. It drives one bit per clock in back-to-back, non-overlapping 6-bit frames, aligned from reset to the detector's slot count. Words come from an upstream valid/ready source through a one-entry holding buffer. When no word is pending at a frame boundary, the idle word is sent and an underrun is flagged.

## Interface
- `W`, default 6: frame width in bits, must be ≥ 2.
- `IDLE_WORD`, default 6'b000000: word sent when no data is pending. It must differ from the detector's match word.
- `clk` input, 1 bit: clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `in_valid` input, 1 bit: upstream word valid.
- `in_ready` output, 1 bit: the block can accept a word this cycle.
- `in_data` input, W bits: upstream word.
- `data_out` output, 1 bit: serial bit for the current slot. Driven directly from a register bit.
- `frame_start` output, 1 bit: high in slot 0 of every frame.
- `underrun` output, 1 bit: one-cycle pulse in slot 0 of a frame that is carrying `IDLE_WORD` because no word was available.

## Operation
- **Slot counter `cnt`:** counts 0..W-1, wraps to 0, and runs freely from reset. `frame_start = (cnt==0)`.
- **Shift register `sreg`:** W bits. `data_out = sreg[W-1]`.
  - On every edge where `cnt != W-1`: `sreg <= {sreg[W-2:0],0}`.
- **Holding buffer:** `hold_valid` and `hold_data`.
  - `in_ready = !hold_valid || (cnt==W-1)`.
  - Accept = `in_valid && in_ready`.
  - On accept when `cnt != W-1`: `hold_data <= in_data` and `hold_valid <= 1`.
- **Frame-boundary load, on the edge where `cnt == W-1`:** `sreg` loads the next word by priority:
  1. If `hold_valid`: load `hold_data`. If an accept also occurs this edge, `in_data` goes into hold and `hold_valid` stays 1. Otherwise `hold_valid <= 0`.
  2. Else, if an accept occurs this edge (bypass): load `in_data`. `hold_valid` stays 0.
  3. Else: load `IDLE_WORD` and set `underrun <= 1`.
- `underrun` is cleared on every other edge.
- A word is never dropped or duplicated. Accepted words are sent in acceptance order.
- **Reset values:**
  - `cnt`, `hold_valid`, `underrun` = 0.
  - `sreg = IDLE_WORD`, so `data_out = IDLE_WORD[W-1]`.
  - `in_ready = 1`, `frame_start = 1`.
- The first frame after reset is always `IDLE_WORD` and is not flagged as an underrun.
- Reset asserted mid-frame discards the frame in flight and any held word. There is no partial-frame recovery.

## Timing
- Cycle 0 is the first cycle after `rst_n` deasserts. Slot k of frame n is cycle 6n+k for W=6. This matches the detector, so when both share `clk` and `rst_n`, the detector samples its first bit in cycle 0 and no alignment handshake is needed.
- **Latency:**
  - Bypass, accepted in slot W-1: the word's first bit appears in the next cycle (slot 0).
  - Accepted in slot k < W-1: the first bit appears W-k cycles later.
- **Throughput:** one word per W cycles. With `in_valid` held high, `in_ready` is high only in slot W-1 once the buffer is full, and output is continuous with no underrun.
- `in_ready` depends combinationally on registered state only, never on `in_valid`.

## Configuration
- Macro `SEQ_TX_LSB_FIRST_EN`.
  - Undefined (default): bit order is MSB-first, `data_out = sreg[W-1]` with a left shift. This is the order the detector expects.
  - Defined: bit order is LSB-first, `data_out = sreg[0]` with a right shift.
- All handshake, underrun and timing behaviour is identical in both builds.

## Structure
- **Package `seq_pkg`:**
  - `FRAME_W = 6`.
  - `IDLE_WORD_DEF = 6'b000000`.
  - `MATCH_WORD = 6'b011100`.
  - `typedef logic [FRAME_W-1:0] frame_t`.
  - The slot counter width, computed as `$clog2(FRAME_W)`.
- **Sub-module `seq_slot_cnt`:** the wrapping 0..W-1 counter with a `last` output. The detector's counter uses the same module, so both sides agree on slot alignment by construction.

## Test plan
1. **Reset and idle:** reset, no writes for 18 cycles.
   - `data_out = 0` in every cycle.
   - `frame_start` high in cycles 0, 6, 12.
   - `underrun` high in cycles 6 and 12 only.
2. **Held write, loopback:** write 6'b011100 in cycle 2.
   - `in_ready` is 0 in cycles 3–4 and 1 in cycle 5.
   - `data_out` in cycles 6..11 = 0,1,1,1,0,0.
   - No underrun in cycle 6.
   - The looped-back detector shows `match = 1` in cycle 12.
3. **Bypass:** hold buffer empty, write 6'b101010 in cycle 5.
   - `data_out` in cycles 6..11 = 1,0,1,0,1,0.
4. **Streaming:** `in_valid` held high with words A, B, C.
   - Accepts occur in cycles 0, 5, 11.
   - A, B, C are sent in cycles 6, 12, 18 with no gaps.
   - `underrun` stays 0 after cycle 0.
5. **Reset mid-frame:** `rst_n` low in cycle 9 with the hold buffer full.
   - `data_out`, `in_ready` and `underrun` take their reset values immediately.
   - After release: one `IDLE_WORD` frame, and the held word is never sent.
6. **LSB-first build:** `SEQ_TX_LSB_FIRST_EN` defined, write 6'b110000 in cycle 5.
   - `data_out` in cycles 6..11 = 0,0,0,0,1,1.
